// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared definitions for the SPI arbiter slice.
//               - SPI_DWIDTH : default byte width, matches spi_core
//               - spi_arb_state_t : arbiter sequencer states
//               - clog2() : ceiling log2, used to size counters/indices
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

  localparam int SPI_DWIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_XFER  = 3'd4,
    ST_READ  = 3'd5,
    ST_CAPT  = 3'd6,
    ST_RESP  = 3'd7
  } spi_arb_state_t;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : spi_rr_pick
// Description : Combinational N-way round-robin picker. Starting one past
//               last_grant and wrapping N-1 -> 0, selects the first set
//               request.
// Ports       : req        in  N   request vector
//               last_grant in  IW  index granted most recently
//               pick       out N   one-hot winner (0 when no request)
//               any        out 1   at least one request is set
// Revision    : 1.0 - initial release
// ============================================================================
module spi_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  pick,
  output logic          any
);

  // One spare bit so last_grant + k cannot overflow before the wrap.
  logic [IW:0] cand;

  always_comb begin
    pick = '0;
    cand = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, last_grant} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) begin
        cand = cand - (IW+1)'(N);
      end
      if (req[cand[IW-1:0]] && (pick == '0)) begin
        pick[cand[IW-1:0]] = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule
`default_nettype wire

// File: rtl/spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_arbiter
// Description : Shares one spi_core master between N requesters. Each byte
//               request is granted round-robin, its slave select is driven
//               low (with optional setup delay), the byte is written to the
//               core, completion is awaited, and the received byte is
//               returned to the owner. req_hold keeps the bus locked for
//               multi-byte frames. A stalled core aborts with err=1.
// Ports       : clk, rst            clock, async active-high reset
//               req/req_data/req_hold  per-requester request, byte, lock
//               gnt, resp_valid      one-hot pulses to the owner
//               resp_data, err       returned byte, timeout flag
//               ss_n                 active-low slave selects
//               core_cs/wr/rd/din    strobes and byte to spi_core
//               core_dout, core_done byte and idle flag from spi_core
// Revision    : 1.0 - initial release
// ============================================================================
module spi_arbiter
  import spi_pkg::*;
#(
  parameter int N        = 4,
  parameter int DWIDTH   = SPI_DWIDTH,
  parameter int SS_SETUP = 2,
  parameter int TIMEOUT  = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N-1:0]          req,
  input  logic [N*DWIDTH-1:0]   req_data,
  input  logic [N-1:0]          req_hold,
  output logic [N-1:0]          gnt,
  output logic [N-1:0]          resp_valid,
  output logic [DWIDTH-1:0]     resp_data,
  output logic                  err,
  output logic [N-1:0]          ss_n,
  output logic                  core_cs,
  output logic                  core_wr,
  output logic                  core_rd,
  output logic [DWIDTH-1:0]     core_din,
  input  logic [DWIDTH-1:0]     core_dout,
  input  logic                  core_done
);

  localparam int IW = (clog2(N) < 1) ? 1 : clog2(N);
  localparam int SW = (clog2(SS_SETUP + 1) < 1) ? 1 : clog2(SS_SETUP + 1);
  localparam int TW = (clog2(TIMEOUT + 1) < 1) ? 1 : clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] SETUP_LAST = SW'((SS_SETUP > 0) ? SS_SETUP - 1 : 0);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT);

  spi_arb_state_t      state_q, state_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [IW-1:0]       last_grant_q, last_grant_d;
  logic                locked_q, locked_d;
  logic                hold_q, hold_d;
  logic [N-1:0]        ss_n_q, ss_n_d;
  logic [N-1:0]        gnt_q, gnt_d;
  logic [N-1:0]        resp_valid_q, resp_valid_d;
  logic [DWIDTH-1:0]   resp_data_q, resp_data_d;
  logic                err_q, err_d;
  logic                core_cs_q, core_cs_d;
  logic                core_wr_q, core_wr_d;
  logic                core_rd_q, core_rd_d;
  logic [DWIDTH-1:0]   core_din_q, core_din_d;
  logic [SW-1:0]       setup_cnt_q, setup_cnt_d;
  logic [TW-1:0]       tmo_cnt_q, tmo_cnt_d;

  logic [N-1:0]        pick;
  logic                pick_any;
  logic [IW-1:0]       pick_idx;
  logic                sel_valid;
  logic                drop_lock;
  logic [IW-1:0]       sel_idx;
  logic [DWIDTH-1:0]   sel_data;

  spi_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req        (req),
    .last_grant (last_grant_q),
    .pick       (pick),
    .any        (pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (pick[i]) begin
        pick_idx = IW'(i);
      end
    end
  end

  // A held lock bypasses the picker: the owner either continues or gives
  // the bus up, and nobody else is considered in that cycle.
  always_comb begin
    sel_valid = 1'b0;
    drop_lock = 1'b0;
    sel_idx   = owner_q;
    if (locked_q) begin
      if (req[owner_q]) begin
        sel_valid = 1'b1;
      end else begin
        drop_lock = 1'b1;
      end
    end else if (pick_any) begin
      sel_valid = 1'b1;
      sel_idx   = pick_idx;
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_idx == IW'(i)) begin
        sel_data = req_data[i*DWIDTH +: DWIDTH];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    locked_d     = locked_q;
    hold_d       = hold_q;
    ss_n_d       = ss_n_q;
    gnt_d        = '0;
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    err_d        = 1'b0;
    core_cs_d    = 1'b0;
    core_wr_d    = 1'b0;
    core_rd_d    = 1'b0;
    core_din_d   = core_din_q;
    setup_cnt_d  = setup_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (core_done) begin
          if (drop_lock) begin
            locked_d = 1'b0;
            ss_n_d   = '1;
          end else if (sel_valid) begin
            owner_d        = sel_idx;
            core_din_d     = sel_data;
            hold_d         = req_hold[sel_idx];
            ss_n_d         = '1;
            ss_n_d[sel_idx] = 1'b0;
            if (ss_n_q[sel_idx] && (SS_SETUP > 0)) begin
              state_d     = ST_SETUP;
              setup_cnt_d = '0;
            end else begin
              state_d         = ST_LOAD;
              gnt_d[sel_idx]  = 1'b1;
              core_cs_d       = 1'b1;
              core_wr_d       = 1'b1;
            end
          end
        end
      end

      ST_SETUP: begin
        if (setup_cnt_q == SETUP_LAST) begin
          state_d        = ST_LOAD;
          setup_cnt_d    = '0;
          gnt_d[owner_q] = 1'b1;
          core_cs_d      = 1'b1;
          core_wr_d      = 1'b1;
        end else begin
          setup_cnt_d = setup_cnt_q + SW'(1);
        end
      end

      ST_LOAD: begin
        state_d   = ST_START;
        tmo_cnt_d = '0;
      end

      // START waits for the core to drop done (it may see the strobe a few
      // cycles late); XFER waits for it to come back. Both are bounded.
      ST_START, ST_XFER: begin
        if ((state_q == ST_START) && !core_done) begin
          state_d   = ST_XFER;
          tmo_cnt_d = '0;
        end else if ((state_q == ST_XFER) && core_done) begin
          state_d   = ST_READ;
          tmo_cnt_d = '0;
          core_cs_d = 1'b1;
          core_rd_d = 1'b1;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d               = ST_RESP;
          tmo_cnt_d             = '0;
          resp_valid_d[owner_q] = 1'b1;
          resp_data_d           = '0;
          err_d                 = 1'b1;
          locked_d              = 1'b0;
          hold_d                = 1'b0;
          ss_n_d                = '1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end

      ST_READ: begin
        state_d = ST_CAPT;
      end

      ST_CAPT: begin
        state_d               = ST_RESP;
        resp_data_d           = core_dout;
        resp_valid_d[owner_q] = 1'b1;
      end

      ST_RESP: begin
        state_d      = ST_IDLE;
        last_grant_d = owner_q;
        locked_d     = hold_q;
        if (!hold_q) begin
          ss_n_d = '1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_grant_q <= IW'(N - 1);
      locked_q     <= 1'b0;
      hold_q       <= 1'b0;
      ss_n_q       <= '1;
      gnt_q        <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      err_q        <= 1'b0;
      core_cs_q    <= 1'b0;
      core_wr_q    <= 1'b0;
      core_rd_q    <= 1'b0;
      core_din_q   <= '0;
      setup_cnt_q  <= '0;
      tmo_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      locked_q     <= locked_d;
      hold_q       <= hold_d;
      ss_n_q       <= ss_n_d;
      gnt_q        <= gnt_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      err_q        <= err_d;
      core_cs_q    <= core_cs_d;
      core_wr_q    <= core_wr_d;
      core_rd_q    <= core_rd_d;
      core_din_q   <= core_din_d;
      setup_cnt_q  <= setup_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
    end
  end

  assign gnt        = gnt_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign err        = err_q;
  assign ss_n       = ss_n_q;
  assign core_cs    = core_cs_q;
  assign core_wr    = core_wr_q;
  assign core_rd    = core_rd_q;
  assign core_din   = core_din_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_arbiter
// Description : Directed self-checking bench for spi_arbiter with a small
//               behavioural spi_core model (done drops 2 cycles after wr,
//               returns T cycles later; can be frozen to force a timeout).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_arbiter;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int SS  = 2;
  localparam int TMO = 20;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_hold;
  logic [N-1:0]      gnt;
  logic [N-1:0]      resp_valid;
  logic [DW-1:0]     resp_data;
  logic              err;
  logic [N-1:0]      ss_n;
  logic              core_cs;
  logic              core_wr;
  logic              core_rd;
  logic [DW-1:0]     core_din;
  logic [DW-1:0]     core_dout;
  logic              core_done;

  int n_cmp = 0;
  int n_err = 0;

  spi_arbiter #(
    .N        (N),
    .DWIDTH   (DW),
    .SS_SETUP (SS),
    .TIMEOUT  (TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .req_hold   (req_hold),
    .gnt        (gnt),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .err        (err),
    .ss_n       (ss_n),
    .core_cs    (core_cs),
    .core_wr    (core_wr),
    .core_rd    (core_rd),
    .core_din   (core_din),
    .core_dout  (core_dout),
    .core_done  (core_done)
  );

  always #5 clk = ~clk;

  // spi_core model
  logic          stuck;
  logic          busy;
  int            t_cnt;
  int            t_len;
  logic [DW-1:0] slave_byte;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_done <= 1'b1;
      busy      <= 1'b0;
      t_cnt     <= 0;
      core_dout <= 8'hEE;
    end else if (core_wr && !stuck) begin
      busy  <= 1'b1;
      t_cnt <= 0;
    end else if (busy) begin
      t_cnt <= t_cnt + 1;
      if (t_cnt == 0) core_done <= 1'b0;
      if (t_cnt == t_len) begin
        core_done <= 1'b1;
        busy      <= 1'b0;
        core_dout <= slave_byte;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Waits for a grant; n_low counts samples with some ss_n low before it.
  task automatic wait_gnt(input string tag, input logic [N-1:0] exp,
                          input logic [DW-1:0] exp_din, output int n_low);
    int k;
    n_low = 0;
    k     = 0;
    @(negedge clk);
    while (gnt == '0 && k < 200) begin
      if (ss_n != '1) n_low++;
      k++;
      @(negedge clk);
    end
    chk({tag, "_gnt"}, gnt, exp);
    chk({tag, "_din"}, core_din, exp_din);
  endtask

  // Waits for resp_valid; ss_n must equal exp_ss on every sample before it.
  task automatic wait_resp(input string tag, input logic [N-1:0] exp,
                           input logic [DW-1:0] exp_data, input logic exp_err,
                           input logic [N-1:0] exp_ss, output int lat);
    logic bad;
    bad = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (resp_valid == '0 && ss_n !== exp_ss) bad = 1'b1;
    end while (resp_valid == '0 && lat < 200);
    chk({tag, "_rv"}, resp_valid, exp);
    chk({tag, "_data"}, resp_data, exp_data);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_ss_held"}, bad, 1'b0);
  endtask

  initial begin
    int           nl;
    int           lat;
    int           ord [5];
    logic [N-1:0] oh;

    rst        = 1'b1;
    req        = '0;
    req_data   = '0;
    req_hold   = '0;
    stuck      = 1'b0;
    t_len      = 3;
    slave_byte = 8'h00;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_ss_n", ss_n, 4'b1111);
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_rv", resp_valid, 4'b0000);
    chk("rst_err", err, 1'b0);
    chk("rst_strobes", {core_cs, core_wr, core_rd}, 3'b000);
    chk("rst_din", core_din, 8'h00);
    chk("rst_rdata", resp_data, 8'h00);
    rst = 1'b0;

    // Fairness: all four requesting, requester 0 wants two bytes
    ord = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 8'h40 + DW'(i);
    req        = 4'b1111;
    slave_byte = 8'h5A;
    for (int b = 0; b < 5; b++) begin
      oh = 4'b0001 << ord[b];
      wait_gnt("fair", oh, 8'h40 + DW'(ord[b]), nl);
      chk("fair_setup_cycles", nl, 2);
      if (b > 0) req = req & ~oh;
      wait_resp("fair", oh, 8'h5A, 1'b0, ~oh, lat);
    end

    // Single request: exact timing
    @(negedge clk);
    chk("single_idle_ss", ss_n, 4'b1111);
    req_data[7:0] = 8'hA5;
    slave_byte    = 8'h3C;
    req[0]        = 1'b1;
    @(negedge clk);
    chk("single_c1_ss", ss_n, 4'b1110);
    chk("single_c1_gnt", gnt, 4'b0000);
    @(negedge clk);
    chk("single_c2_gnt", gnt, 4'b0000);
    @(negedge clk);
    chk("single_c3_gnt", gnt, 4'b0001);
    chk("single_c3_strobes", {core_cs, core_wr, core_rd}, 3'b110);
    chk("single_c3_din", core_din, 8'hA5);
    req[0] = 1'b0;
    wait_resp("single", 4'b0001, 8'h3C, 1'b0, 4'b1110, lat);
    chk("single_latency", lat, 5 + 3);
    chk("single_resp_ss", ss_n, 4'b1110);
    @(negedge clk);
    chk("single_release_ss", ss_n, 4'b1111);

    // Lock: requester 2 sends three bytes while requester 1 waits
    req_data[2*DW +: DW] = 8'h11;
    req_hold[2]          = 1'b1;
    req[2]               = 1'b1;
    slave_byte           = 8'h91;
    wait_gnt("lock1", 4'b0100, 8'h11, nl);
    chk("lock1_setup", nl, 2);
    req_data[1*DW +: DW] = 8'h77;
    req[1]               = 1'b1;
    req_data[2*DW +: DW] = 8'h22;
    wait_resp("lock1", 4'b0100, 8'h91, 1'b0, 4'b1011, lat);
    chk("lock1_resp_ss", ss_n, 4'b1011);
    slave_byte = 8'h92;
    wait_gnt("lock2", 4'b0100, 8'h22, nl);
    chk("lock2_no_setup", nl, 1);
    req_data[2*DW +: DW] = 8'h33;
    req_hold[2]          = 1'b0;
    wait_resp("lock2", 4'b0100, 8'h92, 1'b0, 4'b1011, lat);
    slave_byte = 8'h93;
    wait_gnt("lock3", 4'b0100, 8'h33, nl);
    chk("lock3_no_setup", nl, 1);
    req[2] = 1'b0;
    wait_resp("lock3", 4'b0100, 8'h93, 1'b0, 4'b1011, lat);
    slave_byte = 8'h94;
    wait_gnt("lock_next", 4'b0010, 8'h77, nl);
    chk("lock_next_setup", nl, 2);
    req[1] = 1'b0;
    wait_resp("lock_next", 4'b0010, 8'h94, 1'b0, 4'b1101, lat);

    // Lock abandon: owner 3 locks, then withdraws; requester 0 pending
    req_data[3*DW +: DW] = 8'hC3;
    req_hold[3]          = 1'b1;
    req_data[0*DW +: DW] = 8'h0F;
    req                  = 4'b1001;
    slave_byte           = 8'hB3;
    wait_gnt("aband", 4'b1000, 8'hC3, nl);
    wait_resp("aband", 4'b1000, 8'hB3, 1'b0, 4'b0111, lat);
    req[3]      = 1'b0;
    req_hold[3] = 1'b0;
    @(negedge clk);
    chk("aband_idle_ss", ss_n, 4'b0111);
    chk("aband_idle_gnt", gnt, 4'b0000);
    @(negedge clk);
    chk("aband_release_ss", ss_n, 4'b1111);
    slave_byte = 8'hB0;
    wait_gnt("aband_next", 4'b0001, 8'h0F, nl);
    chk("aband_next_setup", nl, 2);
    req[0] = 1'b0;
    wait_resp("aband_next", 4'b0001, 8'hB0, 1'b0, 4'b1110, lat);

    // Timeout: core never drops done
    stuck                = 1'b1;
    req_data[1*DW +: DW] = 8'h55;
    req_hold[1]          = 1'b1;
    req[1]               = 1'b1;
    wait_gnt("tmo", 4'b0010, 8'h55, nl);
    req[1] = 1'b0;
    wait_resp("tmo", 4'b0010, 8'h00, 1'b1, 4'b1101, lat);
    chk("tmo_latency", lat, TMO + 2);
    chk("tmo_resp_ss", ss_n, 4'b1111);
    req_hold[1] = 1'b0;
    stuck       = 1'b0;

    // Reset mid-XFER
    t_len                = 10;
    req_data[2*DW +: DW] = 8'h2A;
    req[2]               = 1'b1;
    wait_gnt("mid", 4'b0100, 8'h2A, nl);
    req[2] = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_pre_ss", ss_n, 4'b1011);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ss_n", ss_n, 4'b1111);
    chk("mid_rst_gnt_rv", {gnt, resp_valid}, 8'h00);
    chk("mid_rst_strobes", {core_cs, core_wr, core_rd, err}, 4'b0000);
    chk("mid_rst_din", core_din, 8'h00);
    chk("mid_rst_rdata", resp_data, 8'h00);
    @(negedge clk);
    rst   = 1'b0;
    t_len = 3;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = 8'h30 + DW'(i);
    req        = 4'b1111;
    slave_byte = 8'hD0;
    wait_gnt("post_rst", 4'b0001, 8'h30, nl);
    req = 4'b0000;
    wait_resp("post_rst", 4'b0001, 8'hD0, 1'b0, 4'b1110, lat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spi_arbiter.md
# spi_arbiter

Round-robin arbiter and sequencer that shares one `spi_core` master between `N` requesters, each owning one active-low slave select. Accepts a byte per request, drives the core's `cs`/`wr`/`rd` strobes, waits on `done`, reads back the received byte and returns it to the owner. Sits between client logic and `spi_core`, replacing the ad-hoc strobe logic in benches. Optional bus lock supports multi-byte frames.

## Interface
Parameters:
- `N`, 4: number of requesters/slave selects (2..8)
- `DWIDTH`, 8: byte width; must match `spi_core.DWIDTH`
- `SS_SETUP`, 2: cycles `ss_n` is held low before the first byte of a frame (0 allowed)
- `TIMEOUT`, 1023: max cycles waiting on `core_done` per phase before abort

Ports:
- `clk` in 1: system clock
- `rst` in 1: asynchronous reset, active-high
- `req` in N: per-requester byte request, level; held until `gnt`
- `req_data` in N*DWIDTH: byte for requester i at `[i*DWIDTH +: DWIDTH]`
- `req_hold` in N: keep bus locked after this byte
- `gnt` out N: one-hot, 1-cycle pulse; byte accepted
- `resp_valid` out N: one-hot, 1-cycle pulse; `resp_data`/`err` valid
- `resp_data` out DWIDTH: byte received from slave
- `err` out 1: qualifies `resp_valid`; transfer timed out
- `ss_n` out N: slave selects, active low, at most one low
- `core_cs`, `core_wr`, `core_rd` out 1: strobes to `spi_core`
- `core_din` out DWIDTH: byte to `spi_core`
- `core_dout` in DWIDTH: byte from `spi_core`
- `core_done` in 1: `spi_core` idle/complete flag

## Operation
- States: IDLE, SETUP, LOAD, START, XFER, READ, CAPT, RESP.
- IDLE:
  - If locked and `req[owner]`=1, select owner.
  - If locked and `req[owner]`=0, drop the lock, deassert `ss_n`, and stay in IDLE this cycle.
  - If unlocked and any `req` is set, the round-robin picker selects the first requester after the last granted index, wrapping N-1→0.
  - On a selection, register `owner`, `core_din`<=`req_data[owner]` and `hold`<=`req_hold[owner]`.
  - Next state is SETUP if `ss_n[owner]` was high and `SS_SETUP`>0; otherwise LOAD.
  - Requests are ignored while `core_done`=0.
- SETUP: drive `ss_n[owner]` low and count `SS_SETUP` cycles, then go to LOAD.
- LOAD: one cycle with `core_cs`=`core_wr`=1 and `gnt[owner]`=1. Go to START.
- START: wait for `core_done`=0 (core acknowledges, tolerating registered strobes in the path). Then go to XFER.
- XFER: wait for `core_done`=1. Then go to READ.
- READ: one cycle with `core_cs`=`core_rd`=1. Go to CAPT.
- CAPT: `resp_data`<=`core_dout`. Go to RESP.
- RESP: `resp_valid[owner]`=1 for one cycle and `last_grant`<=`owner`.
  - If `hold`=1, keep the lock and `ss_n[owner]` low.
  - If `hold`=0, deassert `ss_n` the next cycle.
  - Go to IDLE.
- Timeout: a cycle counter runs in START and XFER and clears on each state entry. When it reaches `TIMEOUT`:
  - go to RESP with `resp_data`=0 and `err`=1;
  - force the lock off and deassert `ss_n`.
- `core_wr` and `core_rd` are never high together. The strobes are otherwise 0.
- Reset, including mid-transfer: state IDLE, `ss_n` all 1, `gnt`/`resp_valid`/`err`/`core_*` strobes 0, `core_din`=0, `resp_data`=0, `last_grant`=N-1 (so requester 0 wins first), lock cleared, counters 0.

## Timing
- All outputs are registered. No combinational path from `req` or `core_*` inputs to any output.
- Unlocked, `SS_SETUP`=2: `req` high in cycle 0 (IDLE) gives `ss_n` low in cycle 1 and `gnt` in cycle 3.
- With a core that clears `done` 2 cycles after `wr` and completes T cycles later: `resp_valid` arrives 5+T cycles after `gnt`.
- Locked back-to-back byte: `gnt` 1 cycle after IDLE, no SETUP.
- A requester must not change `req_data`/`req_hold` while `req`=1 and before `gnt`. Dropping `req` before `gnt` withdraws the request; if it has already been selected, the byte is still sent.
- `gnt` and `resp_valid` for different requesters never coincide. A new selection is made no earlier than the cycle after RESP.

## Structure
- Shared `spi_pkg`: state enum `spi_arb_state_t`, `SPI_DWIDTH` default, and the timeout-counter width function `clog2`.
- Sub-module `spi_rr_pick`: combinational `N`-way round-robin picker. Inputs are `req` and `last_grant`; outputs are one-hot `pick` and `any`.
- Top level holds the FSM, the lock, the `ss_n` register, and the setup and timeout counters.

## Test plan
- Single request: `req[0]`=1, `req_data`=0xA5, slave model returns 0x3C. Expect `ss_n`=1110 for the whole transfer, one `gnt`=0001, `resp_valid`=0001 with `resp_data`=0x3C and `err`=0, then `ss_n`=1111.
- Fairness: all four `req` held, hold=0. Grant order is 0,1,2,3,0 across 5 bytes, and each `ss_n` edge is preceded by 2 SETUP cycles.
- Lock: `req[2]` with hold=1 for 3 bytes (0x11, 0x22, 0x33) while `req[1]` is pending. Expect three consecutive grants to 2 with `ss_n[2]` continuously low, then requester 1 is granted.
- Lock abandon: owner 3 is locked, then drops `req`. The lock is released in IDLE, `ss_n` goes to 1111, and pending `req[0]` is granted.
- Timeout: `core_done` stuck at 1 after LOAD. After `TIMEOUT` cycles expect `resp_valid` to the owner with `err`=1, `resp_data`=0, and `ss_n` all 1.
- Reset mid-XFER: assert `rst` asynchronously. All outputs take their reset values immediately, and the next request goes to requester 0.
